// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the USB-to-JTAG shift engine.
// Holds the FSM state enum, shift opcode bit positions and legacy command characters.
package jtag_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArg,
        StLow,
        StHigh,
        StResp
    } state_e;

    localparam int unsigned OpShiftBit   = 7;
    localparam int unsigned OpCapBit     = 6;
    localparam int unsigned OpTmsLastBit = 5;

    localparam logic [7:0] CmdPin0   = 8'h30;  // '0'
    localparam logic [7:0] CmdPin7   = 8'h37;  // '7'
    localparam logic [7:0] CmdRstR   = 8'h72;  // 'r'
    localparam logic [7:0] CmdRstU   = 8'h75;  // 'u'
    localparam logic [7:0] CmdLedOn  = 8'h42;  // 'B'
    localparam logic [7:0] CmdLedOff = 8'h62;  // 'b'
    localparam logic [7:0] CmdRead   = 8'h52;  // 'R'
    localparam logic [7:0] CmdDiv    = 8'h44;  // 'D'
    localparam logic [7:0] RespOne   = 8'h31;  // '1'
    localparam logic [7:0] RespZero  = 8'h30;  // '0'

    // 'r','s','t','u' end in 10,11,00,01; flipping bit 1 yields {trst,srst} = 00..11
    function automatic logic [1:0] rst_code(input logic [7:0] cmd);
        return cmd[1:0] ^ 2'b10;
    endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// TCK half-period counter: load sets the count, it then decrements to zero.
// o_tc is high while the count is zero, i.e. on the last cycle of a half-period.
module jtag_tck_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tc
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/jtag_shift_engine.sv
// USB byte-stream to JTAG engine: legacy bitbang commands plus 1..8 bit shift frames
// with optional TDO capture returned as a single response byte.
module jtag_shift_engine
    import jtag_bridge_pkg::*;
#(
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned RESET_DIV = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] from_usb_data_i,
    input  logic       from_usb_valid_i,
    output logic       from_usb_ready_o,
    output logic [7:0] to_usb_data_o,
    output logic       to_usb_valid_o,
    input  logic       to_usb_ready_i,
    output logic       tck_o,
    output logic       tms_o,
    output logic       tdi_o,
    output logic       trst_o,
    output logic       srst_o,
    input  logic       tdo_i,
    output logic       bitbang_led_o,
    output logic       busy_o
);

    state_e           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_arg_div;
    logic             r_cap;
    logic             r_tms_last;
    logic [2:0]       r_nm1;
    logic [2:0]       r_idx;
    logic [7:0]       r_data;
    logic [7:0]       r_capture;
    logic             r_tck, r_tms, r_tdi, r_trst, r_srst, r_led;
    logic [7:0]       r_resp_data;
    logic             r_resp_valid;

    logic             w_ready;
    logic             w_accept;
    logic             w_tc;
    logic             w_load;
    logic [2:0]       w_idx_nxt;

    assign w_ready   = (r_state == StIdle) || (r_state == StArg);
    assign w_accept  = from_usb_valid_i && w_ready;
    assign w_idx_nxt = r_idx + 3'd1;
    // Reload the half-period counter on every TCK phase change
    assign w_load    = (r_state == StArg && w_accept && !r_arg_div) ||
                       ((r_state == StLow || r_state == StHigh) && w_tc);

    jtag_tck_div #(
        .DIV_W (DIV_W)
    ) u_tck_div (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_load (w_load),
        .i_div  (r_div),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_div        <= DIV_W'(RESET_DIV);
            r_arg_div    <= 1'b0;
            r_cap        <= 1'b0;
            r_tms_last   <= 1'b0;
            r_nm1        <= 3'd0;
            r_idx        <= 3'd0;
            r_data       <= 8'h00;
            r_capture    <= 8'h00;
            r_tck        <= 1'b0;
            r_tms        <= 1'b0;
            r_tdi        <= 1'b0;
            r_trst       <= 1'b0;
            r_srst       <= 1'b0;
            r_led        <= 1'b0;
            r_resp_data  <= 8'h00;
            r_resp_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (from_usb_data_i[OpShiftBit]) begin
                            r_cap      <= from_usb_data_i[OpCapBit];
                            r_tms_last <= from_usb_data_i[OpTmsLastBit];
                            r_nm1      <= from_usb_data_i[2:0];
                            r_arg_div  <= 1'b0;
                            r_state    <= StArg;
                        end else if (from_usb_data_i inside {[CmdPin0:CmdPin7]}) begin
                            {r_tck, r_tms, r_tdi} <= from_usb_data_i[2:0];
                        end else if (from_usb_data_i inside {[CmdRstR:CmdRstU]}) begin
                            {r_trst, r_srst} <= rst_code(from_usb_data_i);
                        end else if (from_usb_data_i == CmdLedOn) begin
                            r_led <= 1'b1;
                        end else if (from_usb_data_i == CmdLedOff) begin
                            r_led <= 1'b0;
                        end else if (from_usb_data_i == CmdRead) begin
                            r_resp_data  <= tdo_i ? RespOne : RespZero;
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else if (from_usb_data_i == CmdDiv) begin
                            r_arg_div <= 1'b1;
                            r_state   <= StArg;
                        end
                    end
                end
                StArg: begin
                    if (w_accept) begin
                        if (r_arg_div) begin
                            r_div   <= DIV_W'(from_usb_data_i);
                            r_state <= StIdle;
                        end else begin
                            r_data    <= from_usb_data_i;
                            r_idx     <= 3'd0;
                            r_capture <= 8'h00;
                            r_tck     <= 1'b0;
                            r_tdi     <= from_usb_data_i[0];
                            r_tms     <= (r_nm1 == 3'd0) ? r_tms_last : 1'b0;
                            r_state   <= StLow;
                        end
                    end
                end
                StLow: begin
                    if (w_tc) begin
                        r_tck            <= 1'b1;
                        r_capture[r_idx] <= tdo_i;
                        r_state          <= StHigh;
                    end
                end
                StHigh: begin
                    if (w_tc) begin
                        r_tck <= 1'b0;
                        if (r_idx != r_nm1) begin
                            r_idx   <= w_idx_nxt;
                            r_tdi   <= r_data[w_idx_nxt];
                            r_tms   <= (w_idx_nxt == r_nm1) ? r_tms_last : 1'b0;
                            r_state <= StLow;
                        end else if (r_cap) begin
                            r_resp_data  <= r_capture;
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StResp: begin
                    if (to_usb_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign from_usb_ready_o = w_ready;
    assign busy_o           = (r_state != StIdle);
    assign to_usb_data_o    = r_resp_data;
    assign to_usb_valid_o   = r_resp_valid;
    assign tck_o            = r_tck;
    assign tms_o            = r_tms;
    assign tdi_o            = r_tdi;
    assign trst_o           = r_trst;
    assign srst_o           = r_srst;
    assign bitbang_led_o    = r_led;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine: legacy command table, shift frame timing,
// backpressure, mid-shift reset and a random command stream against a reference model.
module tb_jtag_shift_engine;

    logic       clk;
    logic       rst_i;
    logic [7:0] from_usb_data_i;
    logic       from_usb_valid_i;
    logic       from_usb_ready_o;
    logic [7:0] to_usb_data_o;
    logic       to_usb_valid_o;
    logic       to_usb_ready_i;
    logic       tck_o, tms_o, tdi_o, trst_o, srst_o, tdo_i, bitbang_led_o, busy_o;

    logic       loop_en;
    logic       tdo_force;
    assign tdo_i = loop_en ? tdi_o : tdo_force;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    // model pin state {tck,tms,tdi,trst,srst,led} and divider
    logic [5:0] m_pins;
    int         m_div;

    typedef struct packed {
        logic [7:0] cmd;
        logic [5:0] pins;
    } vec_t;
    vec_t tbl[11];

    jtag_shift_engine #(
        .DIV_W     (8),
        .RESET_DIV (3)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .from_usb_data_i  (from_usb_data_i),
        .from_usb_valid_i (from_usb_valid_i),
        .from_usb_ready_o (from_usb_ready_o),
        .to_usb_data_o    (to_usb_data_o),
        .to_usb_valid_o   (to_usb_valid_o),
        .to_usb_ready_i   (to_usb_ready_i),
        .tck_o            (tck_o),
        .tms_o            (tms_o),
        .tdi_o            (tdi_o),
        .trst_o           (trst_o),
        .srst_o           (srst_o),
        .tdo_i            (tdo_i),
        .bitbang_led_o    (bitbang_led_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] pins();
        return {tck_o, tms_o, tdi_o, trst_o, srst_o, bitbang_led_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Response scoreboard: a transfer happens at the posedge following this negedge
    always @(negedge clk) begin
        if (to_usb_valid_o && to_usb_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {24'h0, to_usb_data_o}, 32'hffff_ffff);
            end else begin
                check("resp_byte", {24'h0, to_usb_data_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        from_usb_data_i  = b;
        from_usb_valid_i = 1'b1;
        while (!from_usb_ready_o && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("send_timeout", 32'(n), 32'd0);
        tick();
        from_usb_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) check("idle_timeout", 32'(n), 32'd0);
    endtask

    // Runs one shift frame with TDO looped to TDI and checks every cycle of the waveform
    task automatic do_shift(input logic [7:0] op, input logic [7:0] data, input int d);
        int n, half, total, bitn, tck_err, tms_err, tdi_err;
        logic [7:0] mask;
        logic exp_tck, exp_tms;
        n     = int'(op[2:0]) + 1;
        half  = d + 1;
        total = 2 * n * half;
        mask  = 8'((1 << n) - 1);
        wait_idle();
        loop_en = 1'b1;
        if (op[6]) exp_q.push_back(data & mask);
        send(op);
        send(data);
        tck_err = 0;
        tms_err = 0;
        tdi_err = 0;
        for (int k = 0; k < total; k++) begin
            bitn    = k / (2 * half);
            exp_tck = ((k / half) % 2) == 1;
            exp_tms = (bitn == n - 1) ? op[5] : 1'b0;
            if (tck_o !== exp_tck) tck_err++;
            if (tms_o !== exp_tms) tms_err++;
            if (tdi_o !== data[bitn]) tdi_err++;
            tick();
        end
        check("tck_pattern", 32'(tck_err), 32'd0);
        check("tms_pattern", 32'(tms_err), 32'd0);
        check("tdi_pattern", 32'(tdi_err), 32'd0);
        check("tck_after", {31'h0, tck_o}, 32'd0);
        check("busy_after", {31'h0, busy_o}, {31'h0, op[6]});
        m_pins[5] = 1'b0;
        m_pins[4] = op[5];
        m_pins[3] = data[n-1];
    endtask

    initial begin
        int rises, err_cnt, r;
        logic prev;
        logic [7:0] b, v;

        checks           = 0;
        errors           = 0;
        rst_i            = 1'b1;
        from_usb_data_i  = 8'h00;
        from_usb_valid_i = 1'b0;
        to_usb_ready_i   = 1'b1;
        loop_en          = 1'b0;
        tdo_force        = 1'b0;

        tbl[0]  = '{8'h35, 6'b101_000};  // '5'
        tbl[1]  = '{8'h42, 6'b101_001};  // 'B'
        tbl[2]  = '{8'h75, 6'b101_111};  // 'u'
        tbl[3]  = '{8'h32, 6'b010_111};  // '2'
        tbl[4]  = '{8'h72, 6'b010_001};  // 'r'
        tbl[5]  = '{8'h73, 6'b010_011};  // 's'
        tbl[6]  = '{8'h62, 6'b010_010};  // 'b'
        tbl[7]  = '{8'h74, 6'b010_100};  // 't'
        tbl[8]  = '{8'h78, 6'b010_100};  // 'x' ignored
        tbl[9]  = '{8'h37, 6'b111_100};  // '7'
        tbl[10] = '{8'h30, 6'b000_100};  // '0'

        tick();
        tick();
        rst_i = 1'b0;
        check("rst_pins", {26'h0, pins()}, 32'd0);
        check("rst_valid", {31'h0, to_usb_valid_o}, 32'd0);
        check("rst_data", {24'h0, to_usb_data_o}, 32'd0);
        check("rst_busy", {31'h0, busy_o}, 32'd0);
        check("rst_ready", {31'h0, from_usb_ready_o}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].cmd);
            check($sformatf("legacy_%0d", i), {26'h0, pins()}, {26'h0, tbl[i].pins});
        end
        m_pins = 6'b000_100;

        do_shift(8'hC7, 8'hA5, 3);

        send(8'h44);
        send(8'h00);
        do_shift(8'hE2, 8'h05, 0);
        wait_idle();
        check("hold_after_shift", {26'h0, pins()}, {26'h0, 6'b011_100});

        send(8'h44);
        send(8'hFF);
        do_shift(8'hC0, 8'h01, 255);
        send(8'h44);
        send(8'h03);

        // Response backpressure
        wait_idle();
        to_usb_ready_i = 1'b0;
        do_shift(8'hC7, 8'hFF, 3);
        err_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (!to_usb_valid_o || to_usb_data_o !== 8'hFF || from_usb_ready_o) err_cnt++;
            tick();
        end
        check("backpressure_hold", 32'(err_cnt), 32'd0);
        to_usb_ready_i = 1'b1;
        tick();
        tick();
        check("backpressure_idle", {31'h0, busy_o}, 32'd0);
        check("backpressure_ready", {31'h0, from_usb_ready_o}, 32'd1);

        // Reset in the middle of a capturing frame
        loop_en = 1'b1;
        send(8'hC7);
        send(8'h3C);
        rises = 0;
        prev  = tck_o;
        for (int k = 0; k < 200 && rises < 4; k++) begin
            tick();
            if (!prev && tck_o) rises++;
            prev = tck_o;
        end
        check("rst_tck_rises", 32'(rises), 32'd4);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_pins", {26'h0, pins()}, 32'd0);
        check("midrst_valid", {31'h0, to_usb_valid_o}, 32'd0);
        check("midrst_busy", {31'h0, busy_o}, 32'd0);
        check("midrst_data", {24'h0, to_usb_data_o}, 32'd0);
        loop_en   = 1'b0;
        tdo_force = 1'b1;
        exp_q.push_back(8'h31);
        send(8'h52);
        wait_idle();
        m_pins = 6'b000_000;
        m_div  = 3;

        // Random interleaved command stream
        for (int i = 0; i < 40; i++) begin
            wait_idle();
            r = $urandom_range(0, 5);
            case (r)
                0: begin
                    b = 8'h30 + 8'($urandom_range(0, 7));
                    send(b);
                    m_pins[5:3] = b[2:0];
                end
                1: begin
                    v = 8'($urandom_range(0, 3));
                    send(8'h72 + v);
                    m_pins[2:1] = v[1:0];
                end
                2: begin
                    v = 8'($urandom_range(0, 1));
                    send(v[0] ? 8'h42 : 8'h62);
                    m_pins[0] = v[0];
                end
                3: begin
                    loop_en   = 1'b0;
                    tdo_force = 1'($urandom_range(0, 1));
                    exp_q.push_back(tdo_force ? 8'h31 : 8'h30);
                    send(8'h52);
                end
                4: begin
                    b = {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00,
                         3'($urandom_range(0, 7))};
                    do_shift(b, 8'($urandom), m_div);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_div = $urandom_range(0, 2);
                        send(8'h44);
                        send(8'(m_div));
                    end else begin
                        v = 8'($urandom_range(0, 2));
                        send(v == 0 ? 8'h41 : (v == 1 ? 8'h7A : 8'h20));
                    end
                end
            endcase
            wait_idle();
            check($sformatf("rand_pins_%0d", i), {26'h0, pins()}, {26'h0, m_pins});
        end

        for (int k = 0; k < 10; k++) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
